// File: rtl/cqf_slot_sched.sv
// cqf_slot_sched: rotates a CQF receive/transmit queue pair across NUM_Q queues
// using a slot index derived from the 48-bit precision time.
module cqf_slot_sched #(
  parameter int unsigned NUM_Q       = 2,
  parameter int unsigned FINE_W      = 17,
  parameter int unsigned FINE_MOD    = 125000,
  parameter int unsigned MIN_EXP     = 7,
  parameter int unsigned MAX_EXP     = 24,
  parameter int unsigned DEFAULT_EXP = 7,
  localparam int unsigned QW         = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [47:0]   precision_time,
  input  logic          cfg_enable,
  input  logic          cfg_wr,
  input  logic [4:0]    cfg_period_exp,
  input  logic [15:0]   cfg_guard,
  output logic          time_slot_flag,
  output logic [QW-1:0] out_rx_q,
  output logic [QW-1:0] out_tx_q,
  output logic          slot_pulse,
  output logic          resync_pulse,
  output logic          guard,
  output logic [4:0]    act_period_exp,
  output logic [31:0]   slot_cnt,
  output logic [15:0]   resync_cnt
);

  localparam int unsigned TW = 32;
  localparam int unsigned EW = 5;

  // Flat time base, slot decode and tracking state
  logic [TW-1:0] st;
  logic [TW-1:0] idx;
  logic [TW-1:0] off;
  logic [TW-1:0] span;
  logic [TW-1:0] guard_len;
  logic          guard_hit;
  logic [TW-1:0] prev_idx;
  logic          prev_valid;
  logic          pending;
  logic [EW-1:0] shadow;
  logic [EW-1:0] exp_clamped;

  // Next-state values
  logic [QW-1:0] rx_nxt;
  logic [QW-1:0] tx_nxt;
  logic [TW-1:0] prev_idx_nxt;
  logic          prev_valid_nxt;
  logic          pending_nxt;
  logic [EW-1:0] shadow_nxt;
  logic [EW-1:0] act_nxt;
  logic          slot_nxt;
  logic          resync_nxt;
  logic          guard_nxt;
  logic [31:0]   slot_cnt_nxt;
  logic [15:0]   resync_cnt_nxt;

  function automatic logic [EW-1:0] clamp_exp(input logic [EW-1:0] e);
    logic [EW-1:0] r;
    r = e;
    if (e < EW'(MIN_EXP)) begin
      r = EW'(MIN_EXP);
    end else if (e > EW'(MAX_EXP)) begin
      r = EW'(MAX_EXP);
    end
    return r;
  endfunction

  assign exp_clamped = clamp_exp(cfg_period_exp);

  // Stage 1: fold {coarse, fine} into a wrapping 32-bit time base (pure pipeline, no reset needed)
  always_ff @(posedge clk) begin
    st <= TW'(TW'(precision_time[47:FINE_W]) * TW'(FINE_MOD)) + TW'(precision_time[FINE_W-1:0]);
  end

  // Slot index / offset under the exponent in force, and guard-band test
  always_comb begin
    span      = TW'(1) << act_period_exp;
    idx       = st >> act_period_exp;
    off       = st & (span - TW'(1));
    guard_len = TW'(cfg_guard);
    guard_hit = prev_valid && (cfg_guard != 16'd0) &&
                ((guard_len >= span) || (off >= (span - guard_len)));
  end

  // Stage 2 decision: silent load, hold, advance or resync; shadow exponent handling
  always_comb begin
    rx_nxt         = out_rx_q;
    prev_idx_nxt   = prev_idx;
    prev_valid_nxt = prev_valid;
    pending_nxt    = pending;
    shadow_nxt     = shadow;
    act_nxt        = act_period_exp;
    slot_nxt       = 1'b0;
    resync_nxt     = 1'b0;
    guard_nxt      = 1'b0;
    slot_cnt_nxt   = slot_cnt;
    resync_cnt_nxt = resync_cnt;

    if (!cfg_enable) begin
      rx_nxt         = '0;
      prev_valid_nxt = 1'b0;
      // With the scheduler idle there is no boundary to wait for
      if (cfg_wr) begin
        shadow_nxt  = exp_clamped;
        act_nxt     = exp_clamped;
        pending_nxt = 1'b0;
      end else if (pending) begin
        act_nxt     = shadow;
        pending_nxt = 1'b0;
      end
    end else begin
      guard_nxt = guard_hit;
      if (!prev_valid) begin
        prev_idx_nxt   = idx;
        rx_nxt         = idx[QW-1:0];
        prev_valid_nxt = 1'b1;
      end else if (idx != prev_idx) begin
        prev_idx_nxt = idx;
        if (idx == (prev_idx + TW'(1))) begin
          rx_nxt       = out_rx_q + QW'(1);
          slot_nxt     = 1'b1;
          slot_cnt_nxt = slot_cnt + 32'd1;
        end else begin
          rx_nxt     = idx[QW-1:0];
          resync_nxt = 1'b1;
          if (resync_cnt != 16'hFFFF) begin
            resync_cnt_nxt = resync_cnt + 16'd1;
          end
        end
        // New exponent takes effect here; next cycle reloads the index silently
        if (pending) begin
          act_nxt        = shadow;
          pending_nxt    = 1'b0;
          prev_valid_nxt = 1'b0;
        end
      end
      // A write on a boundary queues behind the value applied above
      if (cfg_wr) begin
        shadow_nxt  = exp_clamped;
        pending_nxt = 1'b1;
      end
    end

    tx_nxt = rx_nxt - QW'(1);
  end

  // Output and state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      out_rx_q       <= '0;
      out_tx_q       <= QW'(NUM_Q - 1);
      time_slot_flag <= 1'b0;
      slot_pulse     <= 1'b0;
      resync_pulse   <= 1'b0;
      guard          <= 1'b0;
      act_period_exp <= EW'(DEFAULT_EXP);
      slot_cnt       <= 32'd0;
      resync_cnt     <= 16'd0;
      prev_idx       <= '0;
      prev_valid     <= 1'b0;
      pending        <= 1'b0;
      shadow         <= EW'(DEFAULT_EXP);
    end else begin
      out_rx_q       <= rx_nxt;
      out_tx_q       <= tx_nxt;
      time_slot_flag <= rx_nxt[0];
      slot_pulse     <= slot_nxt;
      resync_pulse   <= resync_nxt;
      guard          <= guard_nxt;
      act_period_exp <= act_nxt;
      slot_cnt       <= slot_cnt_nxt;
      resync_cnt     <= resync_cnt_nxt;
      prev_idx       <= prev_idx_nxt;
      prev_valid     <= prev_valid_nxt;
      pending        <= pending_nxt;
      shadow         <= shadow_nxt;
    end
  end

endmodule

// File: tb/tb_cqf_slot_sched.sv
// Bench for cqf_slot_sched: NUM_Q=4 and NUM_Q=2 instances share stimulus and
// are compared against a time-arithmetic reference model.
module tb_cqf_slot_sched;

  localparam int unsigned FMOD = 125000;

  logic        clk;
  logic        rst;
  logic [47:0] precision_time;
  logic        cfg_enable;
  logic        cfg_wr;
  logic [4:0]  cfg_period_exp;
  logic [15:0] cfg_guard;

  logic        flag_a, slot_a, resync_a, guard_a;
  logic [1:0]  rx_a, tx_a;
  logic [4:0]  act_a;
  logic [31:0] scnt_a;
  logic [15:0] rcnt_a;

  logic        flag_b, slot_b, resync_b, guard_b;
  logic [0:0]  rx_b, tx_b;
  logic [4:0]  act_b;
  logic [31:0] scnt_b;
  logic [15:0] rcnt_b;

  logic [60:0] got_a;
  logic [58:0] got_b;
  assign got_a = {rx_a, tx_a, flag_a, slot_a, resync_a, guard_a, act_a, scnt_a, rcnt_a};
  assign got_b = {rx_b, tx_b, flag_b, slot_b, resync_b, guard_b, act_b, scnt_b, rcnt_b};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: rx kept modulo 8 so both queue counts derive from it
  longint unsigned m_st, m_prev, e_scnt;
  bit              m_pv, m_pend, e_slot, e_resync, e_guard;
  int              m_exp, m_shadow, e_rx, e_rcnt;

  cqf_slot_sched #(.NUM_Q(4)) dut_a (
    .clk(clk), .rst(rst), .precision_time(precision_time), .cfg_enable(cfg_enable),
    .cfg_wr(cfg_wr), .cfg_period_exp(cfg_period_exp), .cfg_guard(cfg_guard),
    .time_slot_flag(flag_a), .out_rx_q(rx_a), .out_tx_q(tx_a), .slot_pulse(slot_a),
    .resync_pulse(resync_a), .guard(guard_a), .act_period_exp(act_a),
    .slot_cnt(scnt_a), .resync_cnt(rcnt_a));

  cqf_slot_sched #(.NUM_Q(2)) dut_b (
    .clk(clk), .rst(rst), .precision_time(precision_time), .cfg_enable(cfg_enable),
    .cfg_wr(cfg_wr), .cfg_period_exp(cfg_period_exp), .cfg_guard(cfg_guard),
    .time_slot_flag(flag_b), .out_rx_q(rx_b), .out_tx_q(tx_b), .slot_pulse(slot_b),
    .resync_pulse(resync_b), .guard(guard_b), .act_period_exp(act_b),
    .slot_cnt(scnt_b), .resync_cnt(rcnt_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic longint unsigned flat_time(input logic [47:0] pt);
    longint unsigned c, f;
    c = 64'(pt[47:17]);
    f = 64'(pt[16:0]);
    return (c * FMOD + f) % 64'h1_0000_0000;
  endfunction

  function automatic int clampf(input int e);
    return (e < 7) ? 7 : ((e > 24) ? 24 : e);
  endfunction

  function automatic logic [60:0] exp_a();
    return {2'(e_rx % 4), 2'((e_rx + 3) % 4), 1'(e_rx % 2), e_slot, e_resync, e_guard,
            5'(m_exp), 32'(e_scnt), 16'(e_rcnt)};
  endfunction

  function automatic logic [58:0] exp_b();
    return {1'(e_rx % 2), 1'((e_rx + 1) % 2), 1'(e_rx % 2), e_slot, e_resync, e_guard,
            5'(m_exp), 32'(e_scnt), 16'(e_rcnt)};
  endfunction

  // One clock edge of the reference: slot = time / 2^exp, offset = time % 2^exp
  task automatic model_edge();
    longint unsigned span, idx, off, g;
    if (rst) begin
      m_pv = 0; m_pend = 0; m_prev = 0; m_exp = 7; m_shadow = 7;
      e_rx = 0; e_rcnt = 0; e_scnt = 0; e_slot = 0; e_resync = 0; e_guard = 0;
    end else begin
      span = 64'd1 << m_exp;
      idx  = m_st / span;
      off  = m_st % span;
      g    = 64'(cfg_guard);
      e_slot = 0; e_resync = 0; e_guard = 0;
      if (!cfg_enable) begin
        e_rx = 0;
        m_pv = 0;
        if (cfg_wr) begin
          m_exp = clampf(int'(cfg_period_exp));
          m_pend = 0;
        end else if (m_pend) begin
          m_exp = m_shadow;
          m_pend = 0;
        end
      end else begin
        e_guard = m_pv && (g != 0) && ((g >= span) || (off >= span - g));
        if (!m_pv) begin
          m_prev = idx;
          e_rx = int'(idx % 64'd8);
          m_pv = 1;
        end else if (idx != m_prev) begin
          if (idx == m_prev + 1) begin
            e_rx = (e_rx + 1) % 8;
            e_slot = 1;
            e_scnt = (e_scnt + 1) % 64'h1_0000_0000;
          end else begin
            e_rx = int'(idx % 64'd8);
            e_resync = 1;
            if (e_rcnt < 65535) e_rcnt++;
          end
          m_prev = idx;
          if (m_pend) begin
            m_exp = m_shadow;
            m_pend = 0;
            m_pv = 0;
          end
        end
        if (cfg_wr) begin
          m_shadow = clampf(int'(cfg_period_exp));
          m_pend = 1;
        end
      end
    end
    m_st = flat_time(precision_time);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; cfg_enable = 0; cfg_wr = 0; cfg_period_exp = 5'd7; cfg_guard = 16'd0;
    precision_time = 48'd0;
    tick();
    n_checks++;
    if ({rx_a, tx_a, flag_a, slot_a, resync_a, guard_a} !== {2'd0, 2'd3, 1'b0, 3'b000}) begin
      n_errors++;
      $display("FAIL reset_queues got=%h want=%h", {rx_a, tx_a, flag_a, slot_a, resync_a, guard_a}, 8'h30);
    end
    n_checks++;
    if ({act_a, scnt_a, rcnt_a} !== {5'd7, 32'd0, 16'd0}) begin
      n_errors++;
      $display("FAIL reset_regs got act=%0d scnt=%0d rcnt=%0d want 7/0/0", act_a, scnt_a, rcnt_a);
    end
    n_checks++;
    if ({rx_b, tx_b, flag_b} !== 3'b010) begin
      n_errors++;
      $display("FAIL reset_q2 got=%b want=010", {rx_b, tx_b, flag_b});
    end
  endtask

  task automatic test_slot_advance();
    int pulses;
    pulses = 0;
    precision_time = 48'd0; rst = 1; tick();
    rst = 0; cfg_enable = 1;
    for (int f = 0; f <= 664; f += 8) begin
      precision_time = 48'((f > 648) ? 648 : f);
      tick();
      pulses += int'(slot_a);
      n_checks++;
      if (got_a !== exp_a() || got_b !== exp_b()) begin
        n_errors++;
        $display("FAIL advance f=%0d got=%h/%h want=%h/%h", f, got_a, got_b, exp_a(), exp_b());
      end
    end
    n_checks++;
    if (pulses !== 5) begin
      n_errors++;
      $display("FAIL advance_pulses got=%0d want=5", pulses);
    end
    n_checks++;
    if ({scnt_a, rx_a, tx_a, rcnt_a} !== {32'd5, 2'd1, 2'd0, 16'd0}) begin
      n_errors++;
      $display("FAIL advance_end got scnt=%0d rx=%0d tx=%0d rcnt=%0d want 5/1/0/0", scnt_a, rx_a, tx_a, rcnt_a);
    end
  endtask

  task automatic test_resync();
    precision_time = 48'd8; rst = 1; tick();
    rst = 0; cfg_enable = 1;
    repeat (3) tick();
    precision_time = 48'd1000;
    tick();
    tick();
    n_checks++;
    if ({resync_a, slot_a, rx_b, rx_a, rcnt_a} !== {1'b1, 1'b0, 1'b1, 2'd3, 16'd1}) begin
      n_errors++;
      $display("FAIL resync got rs=%b sp=%b rx2=%0d rx4=%0d rcnt=%0d want 1/0/1/3/1", resync_a, slot_a, rx_b, rx_a, rcnt_a);
    end
    n_checks++;
    if (got_a !== exp_a()) begin
      n_errors++;
      $display("FAIL resync_model got=%h want=%h", got_a, exp_a());
    end
    tick();
    n_checks++;
    if ({resync_a, rcnt_a} !== {1'b0, 16'd1}) begin
      n_errors++;
      $display("FAIL resync_after got rs=%b rcnt=%0d want 0/1", resync_a, rcnt_a);
    end
  endtask

  task automatic test_shadow();
    precision_time = 48'd0; rst = 1; tick();
    rst = 0; cfg_enable = 1; cfg_period_exp = 5'd8;
    for (int f = 0; f <= 520; f += 8) begin
      precision_time = 48'((f > 504) ? 504 : f);
      cfg_wr = (f == 200);
      tick();
      cfg_wr = 0;
      n_checks++;
      if (got_a !== exp_a() || got_b !== exp_b()) begin
        n_errors++;
        $display("FAIL shadow f=%0d got=%h want=%h", f, got_a, exp_a());
      end
      if (f == 136 || f == 264 || f == 392) begin
        n_checks++;
        if (slot_a !== ((f == 392) ? 1'b0 : 1'b1)) begin
          n_errors++;
          $display("FAIL shadow_pulse f=%0d got=%b", f, slot_a);
        end
      end
    end
    n_checks++;
    if ({act_a, scnt_a, rcnt_a} !== {5'd8, 32'd2, 16'd0}) begin
      n_errors++;
      $display("FAIL shadow_apply got act=%0d scnt=%0d rcnt=%0d want 8/2/0", act_a, scnt_a, rcnt_a);
    end
    precision_time = 48'd520;
    tick();
    tick();
    n_checks++;
    if ({slot_a, scnt_a, act_a, rcnt_a} !== {1'b1, 32'd3, 5'd8, 16'd0}) begin
      n_errors++;
      $display("FAIL shadow_512 got sp=%b scnt=%0d act=%0d rcnt=%0d want 1/3/8/0", slot_a, scnt_a, act_a, rcnt_a);
    end
  endtask

  task automatic test_clamp_guard();
    int req[4];
    int want[4];
    int gcount;
    int stv;
    logic gw;
    req = '{3, 30, 9, 3};
    want = '{7, 24, 9, 7};
    precision_time = 48'd0; cfg_guard = 16'd0; rst = 1; tick();
    rst = 0; cfg_enable = 0;
    for (int i = 0; i < 4; i++) begin
      cfg_period_exp = 5'(req[i]);
      cfg_wr = 1;
      tick();
      cfg_wr = 0;
      tick();
      n_checks++;
      if (act_a !== 5'(want[i]) || got_a !== exp_a()) begin
        n_errors++;
        $display("FAIL clamp req=%0d got=%0d want=%0d", req[i], act_a, want[i]);
      end
    end
    cfg_guard = 16'd16; cfg_enable = 1; gcount = 0;
    for (int f = 0; f <= 301; f++) begin
      precision_time = 48'((f > 299) ? 299 : f);
      tick();
      gcount += int'(guard_a);
      n_checks++;
      if (got_a !== exp_a()) begin
        n_errors++;
        $display("FAIL guard_model f=%0d got=%h want=%h", f, got_a, exp_a());
      end
      if (f >= 1) begin
        stv = (f - 1 > 299) ? 299 : f - 1;
        gw = ((stv % 128) >= 112);
        n_checks++;
        if (guard_a !== gw) begin
          n_errors++;
          $display("FAIL guard16 off=%0d got=%b want=%b", stv % 128, guard_a, gw);
        end
      end
    end
    n_checks++;
    if (gcount !== 32) begin
      n_errors++;
      $display("FAIL guard_count got=%0d want=32", gcount);
    end
    cfg_guard = 16'd200;
    repeat (3) begin
      tick();
      n_checks++;
      if (guard_a !== 1'b1) begin
        n_errors++;
        $display("FAIL guard_wide got=%b want=1", guard_a);
      end
    end
    cfg_guard = 16'd0;
  endtask

  task automatic test_midreset();
    int f;
    bit found;
    f = 256; found = 0;
    precision_time = 48'(f); rst = 1; tick();
    rst = 0; cfg_enable = 1;
    for (int k = 0; k < 200 && !found; k++) begin
      precision_time = 48'(f);
      tick();
      n_checks++;
      if (got_a !== exp_a()) begin
        n_errors++;
        $display("FAIL midreset_run f=%0d got=%h want=%h", f, got_a, exp_a());
      end
      if (scnt_a == 32'd9) found = 1;
      else f += 16;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL midreset_timeout got scnt=%0d want 9", scnt_a);
    end
    tick();
    n_checks++;
    if ({rx_a, scnt_a} !== {2'd3, 32'd9}) begin
      n_errors++;
      $display("FAIL midreset_pre got rx=%0d scnt=%0d want 3/9", rx_a, scnt_a);
    end
    rst = 1;
    tick();
    rst = 0;
    n_checks++;
    if (got_a !== {2'd0, 2'd3, 1'b0, 3'b000, 5'd7, 32'd0, 16'd0}) begin
      n_errors++;
      $display("FAIL midreset_clear got=%h", got_a);
    end
    tick();
    n_checks++;
    if ({slot_a, resync_a, scnt_a, rcnt_a, rx_a} !== {1'b0, 1'b0, 32'd0, 16'd0, 2'((f / 128) % 4)}) begin
      n_errors++;
      $display("FAIL midreset_load got sp=%b rs=%b scnt=%0d rcnt=%0d rx=%0d want rx=%0d",
               slot_a, resync_a, scnt_a, rcnt_a, rx_a, (f / 128) % 4);
    end
  endtask

  task automatic test_random();
    longint unsigned t;
    int r;
    t = 0;
    precision_time = 48'd0; cfg_guard = 16'd0; cfg_wr = 0; rst = 1; tick();
    rst = 0; cfg_enable = 1;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 20) t += 64'($urandom_range(0, 1 << 20));
      else if (r < 30) t = (t > 4000) ? t - 4000 : 0;
      else t += 64'($urandom_range(0, 40));
      precision_time = {31'(t / FMOD), 17'(t % FMOD)};
      cfg_wr = ($urandom_range(0, 99) < 3);
      cfg_period_exp = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(6, 10));
      if ($urandom_range(0, 99) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 49) == 0) cfg_guard = 16'($urandom_range(0, 300));
      rst = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if (got_a !== exp_a()) begin
        n_errors++;
        $display("FAIL rand_q4 cyc=%0d got=%h want=%h", i, got_a, exp_a());
      end
      n_checks++;
      if (got_b !== exp_b()) begin
        n_errors++;
        $display("FAIL rand_q2 cyc=%0d got=%h want=%h", i, got_b, exp_b());
      end
    end
    rst = 0; cfg_wr = 0;
  endtask

  initial begin
    test_reset();
    test_slot_advance();
    test_resync();
    test_shadow();
    test_clamp_guard();
    test_midreset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
